// File: rtl/ray_stage_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : ray_stage_fifo_if
// Purpose  : Valid/ready handshake bundle between two RayCore pipeline stages.
// Revision : 1.0 - initial release
// ============================================================================
interface ray_stage_fifo_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_ready;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  i_ready;

  // FIFO side
  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data
  );

  // Producer/consumer side
  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data
  );
endinterface
`default_nettype wire

// File: rtl/ray_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ray_stage_fifo
// Purpose  : Show-ahead ring-buffer FIFO decoupling two RayCore stages.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef STAGE_FIFO_SIZE_WIDTH
`define STAGE_FIFO_SIZE_WIDTH 4
`endif

module ray_stage_fifo #(
  parameter int DATA_WIDTH        = 128,
  parameter int WIDTH             = `STAGE_FIFO_SIZE_WIDTH,
  parameter int SIZE              = 2**WIDTH,
  parameter int ALMOST_FULL_LEVEL = SIZE-3
) (
  input  wire logic             clk,
  input  wire logic             resetn,
  input  wire logic             i_flush,
  ray_stage_fifo_if.slave       s,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_almost_full
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_af  = WIDTH'(ALMOST_FULL_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [SIZE];
  logic [WIDTH-1:0]      r_top;
  logic [WIDTH-1:0]      r_bottom;
  logic [WIDTH-1:0]      r_count;
  logic                  r_almost_full;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [WIDTH-1:0]      w_count_next;

  // One slot stays unused so that top==bottom always means empty.
  assign w_empty = (r_top == r_bottom);
  assign w_full  = ((r_bottom + c_one) == r_top);

  assign s.o_ready = resetn & ~w_full;
  assign s.o_valid = ~w_empty;
  assign s.o_data  = r_mem[r_top];

  assign w_push = s.i_valid & s.o_ready;
  assign w_pop  = s.o_valid & s.i_ready;

  always_comb begin
    w_count_next = r_count;
    if (i_flush) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + c_one;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - c_one;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_top         <= '0;
      r_bottom      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      if (i_flush) begin
        r_top    <= '0;
        r_bottom <= '0;
      end else begin
        if (w_push) r_bottom <= r_bottom + c_one;
        if (w_pop)  r_top    <= r_top + c_one;
      end
      r_count       <= w_count_next;
      r_almost_full <= (w_count_next >= c_af);
    end
  end

  // Storage is intentionally not reset; a flushed push never lands.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_bottom] <= s.i_data;
    end
  end

  assign o_count       = r_count;
  assign o_almost_full = r_almost_full;

endmodule
`default_nettype wire

// File: tb/tb_ray_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ray_stage_fifo
// Purpose  : Directed self-checking bench for ray_stage_fifo (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ray_stage_fifo;

  localparam int c_dw    = 128;
  localparam int c_width = 4;

  logic               clk;
  logic               resetn;
  logic               i_flush;
  logic [c_width-1:0] o_count;
  logic               o_almost_full;
  int                 n_chk;
  int                 n_pass;

  ray_stage_fifo_if #(.DATA_WIDTH(c_dw)) bus ();

  ray_stage_fifo #(
    .DATA_WIDTH (c_dw),
    .WIDTH      (c_width)
  ) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_flush       (i_flush),
    .s             (bus.slave),
    .o_count       (o_count),
    .o_almost_full (o_almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [c_dw-1:0] act, input logic [c_dw-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Advance one edge; inputs and samples sit 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill15(input int base);
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      bus.i_data = c_dw'(base + i);
      step();
      chk("fill_count", c_dw'(o_count), c_dw'(i + 1));
      chk("fill_af", c_dw'(o_almost_full), c_dw'(i + 1 >= 13));
      chk("fill_ready", c_dw'(bus.o_ready), c_dw'(i + 1 < 15));
    end
    bus.i_data = c_dw'(32'hDEAD);
    step();
    chk("full_reject_count", c_dw'(o_count), c_dw'(15));
    bus.i_valid = 1'b0;
    chk("full_head", bus.o_data, c_dw'(base));
  endtask

  task automatic drain(input int base, input int n);
    bus.i_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", c_dw'(bus.o_valid), c_dw'(1));
      chk("drain_data", bus.o_data, c_dw'(base + i));
      step();
    end
    bus.i_ready = 1'b0;
  endtask

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    resetn       = 1'b0;
    i_flush      = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b0;
    bus.i_data   = '0;

    // Reset / idle
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", c_dw'(bus.o_ready), c_dw'(0));
      chk("rst_valid", c_dw'(bus.o_valid), c_dw'(0));
      chk("rst_count", c_dw'(o_count), c_dw'(0));
    end
    resetn = 1'b1;
    step();
    chk("post_rst_ready", c_dw'(bus.o_ready), c_dw'(1));
    chk("post_rst_valid", c_dw'(bus.o_valid), c_dw'(0));
    chk("post_rst_af", c_dw'(o_almost_full), c_dw'(0));

    // Fill, drain, then a second round that wraps the pointers
    fill15(32'h1);
    drain(32'h1, 15);
    chk("empty_valid", c_dw'(bus.o_valid), c_dw'(0));
    chk("empty_count", c_dw'(o_count), c_dw'(0));
    fill15(32'h10);
    drain(32'h10, 15);
    chk("wrap_empty_valid", c_dw'(bus.o_valid), c_dw'(0));

    // Streaming push+pop at occupancy 5
    bus.i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.i_data = c_dw'(32'h100 + i);
      step();
    end
    chk("stream_pre_count", c_dw'(o_count), c_dw'(5));
    bus.i_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.i_data = c_dw'(32'h105 + k);
      chk("stream_data", bus.o_data, c_dw'(32'h100 + k));
      step();
      chk("stream_count", c_dw'(o_count), c_dw'(5));
    end
    bus.i_valid = 1'b0;
    drain(32'h114, 5);
    chk("stream_end_valid", c_dw'(bus.o_valid), c_dw'(0));

    // Full with both sides active: only the pop happens
    fill15(32'h200);
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    bus.i_data  = c_dw'(32'h2FF);
    chk("full_both_ready", c_dw'(bus.o_ready), c_dw'(0));
    step();
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    chk("full_both_count", c_dw'(o_count), c_dw'(14));
    chk("full_both_ready_next", c_dw'(bus.o_ready), c_dw'(1));
    chk("full_both_head", bus.o_data, c_dw'(32'h201));
    drain(32'h201, 7);
    chk("pre_flush_count", c_dw'(o_count), c_dw'(7));

    // Flush beats a simultaneous push and pop
    i_flush     = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    bus.i_data  = c_dw'(32'hAA);
    step();
    i_flush     = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    chk("flush_count", c_dw'(o_count), c_dw'(0));
    chk("flush_valid", c_dw'(bus.o_valid), c_dw'(0));
    chk("flush_af", c_dw'(o_almost_full), c_dw'(0));
    bus.i_valid = 1'b1;
    bus.i_data  = c_dw'(32'hBB);
    step();
    bus.i_valid = 1'b0;
    chk("after_flush_count", c_dw'(o_count), c_dw'(1));
    drain(32'hBB, 1);
    chk("after_flush_empty", c_dw'(bus.o_valid), c_dw'(0));

    // Asynchronous reset mid-stream at occupancy 9
    bus.i_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.i_data = c_dw'(32'h300 + i);
      step();
    end
    bus.i_valid = 1'b0;
    chk("pre_arst_count", c_dw'(o_count), c_dw'(9));
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", c_dw'(bus.o_valid), c_dw'(0));
    chk("arst_count", c_dw'(o_count), c_dw'(0));
    chk("arst_ready", c_dw'(bus.o_ready), c_dw'(0));
    step();
    step();
    resetn = 1'b1;
    step();
    chk("arst_rel_ready", c_dw'(bus.o_ready), c_dw'(1));
    chk("arst_rel_valid", c_dw'(bus.o_valid), c_dw'(0));
    bus.i_valid = 1'b1;
    bus.i_data  = c_dw'(32'h55);
    step();
    bus.i_valid = 1'b0;
    chk("arst_push_count", c_dw'(o_count), c_dw'(1));
    chk("arst_push_data", bus.o_data, c_dw'(32'h55));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ray_stage_fifo.md
Name: ray_stage_fifo

Overview:
- Ring-buffer FIFO placed between two RayCore pipeline stages. It decouples the producer stage (for example, ray generation) from the consumer stage (for example, traversal).
- Uses a read pointer (top) and a write pointer (bottom) with one-slot-reserved full detection, so usable capacity is SIZE-1.
- Valid/ready handshake on both sides, plus occupancy and almost-full outputs for upstream throttling.

Parameters:
- DATA_WIDTH, 128, payload width in bits (packed ray/stage record).
- WIDTH, `STAGE_FIFO_SIZE_WIDTH, pointer width in bits.
- SIZE, 2**WIDTH, number of storage slots; capacity is SIZE-1.
- ALMOST_FULL_LEVEL, SIZE-3, occupancy at or above which o_almost_full asserts.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- i_flush  input  1  synchronous flush; empties the FIFO.
- i_valid  input  1  producer offers i_data this cycle.
- i_data  input  DATA_WIDTH  producer payload.
- o_ready  output  1  FIFO accepts a push this cycle.
- o_valid  output  1  head entry available on o_data.
- o_data  output  DATA_WIDTH  head entry (show-ahead).
- i_ready  input  1  consumer takes the head this cycle.
- o_count  output  WIDTH  current occupancy, 0..SIZE-1.
- o_almost_full  output  1  o_count >= ALMOST_FULL_LEVEL.

Behaviour:
- State: mem[SIZE] of DATA_WIDTH; top (read pointer), bottom (write pointer), both WIDTH bits. Pointers wrap naturally modulo SIZE.
- Reset (resetn low, asynchronous): top=0, bottom=0, o_valid=0, o_count=0, o_almost_full=0. o_ready is forced 0 while resetn is low and rises the first cycle after deassertion. mem contents are not reset; o_data is don't-care while o_valid=0.
- empty = (top == bottom).
- full: if bottom > top, full = ({1'b0,top} + SIZE - {1'b0,bottom}) == 1; otherwise full = (top - bottom) == 1. This is equivalent to (bottom+1) mod SIZE == top.
- o_ready = resetn & ~full. It does not depend on i_ready; there is no pass-through on a full-FIFO pop.
- o_valid = ~empty. There is no bypass: a push into an empty FIFO becomes visible on o_valid the next cycle (latency 1).
- o_data = mem[top], read combinationally.
- push = i_valid & o_ready. On push: mem[bottom] <= i_data; bottom <= bottom+1.
- pop = o_valid & i_ready. On pop: top <= top+1.
- Simultaneous push and pop: both occur and o_count is unchanged. This is legal at any non-full, non-empty occupancy.
- Full with i_valid and i_ready both high: only the pop happens; o_ready is high the next cycle.
- o_count is registered: +1 on push only, -1 on pop only, unchanged on both or neither. It must always equal (bottom - top) mod SIZE.
- o_almost_full is registered from the next-state count.
- i_flush has priority over push and pop in the same cycle. Next state: top=bottom=0, o_count=0, o_valid=0. A push presented in the flush cycle is dropped, even if o_ready was high.
- Producer rule: i_data/i_valid must stay stable while i_valid=1 and o_ready=0. Violations are not corrected by the FIFO.
- Reset asserted mid-operation: all contents are lost immediately and asynchronously; no pop is reported.
- Assertions for the bench:
  - No push while full.
  - No pop while empty.
  - o_count never reaches SIZE.

Test Plan:
- Reset/idle (WIDTH=4, SIZE=16): hold resetn low 3 cycles, then release -> during reset o_ready=0, o_valid=0, o_count=0; the cycle after release o_ready=1, o_valid still 0.
- Fill to capacity: push 0x1..0xF on consecutive cycles with i_ready=0 -> o_count reaches 15, o_ready=0 after the 15th push, 16th push not accepted, o_almost_full=1 from count 13 onward.
- Drain order and wrap: from full, i_ready=1 -> o_data yields 0x1..0xF in order over 15 cycles, then o_valid=0. Repeat the fill with values 0x10..0x1E so pointers wrap past 15 -> same ordering and count behaviour.
- Simultaneous push/pop at count 5 for 20 cycles, streaming 0x100.. -> o_count stays 5, output sequence continuous with no loss or duplication. Again at count 15 with i_valid=i_ready=1 -> only the pop occurs, count 14, o_ready=1 the next cycle.
- Flush: at count 7 assert i_flush together with i_valid=1 (data 0xAA) and i_ready=1 -> next cycle o_count=0, o_valid=0; 0xAA is never output; a subsequent push of 0xBB appears first.
- Async reset mid-stream: at count 9, drop resetn between clock edges -> o_valid and o_count go to 0 immediately, without waiting for a clock edge; after release the FIFO behaves as in the first scenario.
